alu_ctrl_seq: RTL

//  Registered, parametrised ALU control for the EX stage. Decodes aluOp/funct into an ALU operation

---
 rtl/alu_ctrl_seq_if.sv | 25 ++
 rtl/alu_ctrl_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq_if.sv
// EX-stage ALU control bus: decode request from ID/EX and registered operation/status back.
interface alu_ctrl_seq_if #(
  parameter int FUNCT_W = 4,
  parameter int OP_W    = 4
);
  logic               valid_in;
  logic [1:0]         aluOp;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic [OP_W-1:0]    operation;
  logic               op_valid;
  logic               stall;
  logic               done;
  logic               illegal;

  modport master (
    output valid_in, aluOp, funct, flush,
    input  operation, op_valid, stall, done, illegal
  );

  modport slave (
    input  valid_in, aluOp, funct, flush,
    output operation, op_valid, stall, done, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered EX-stage ALU control with multi-cycle mul/div sequencing and stall generation.
// Optional macro ALU_CTRL_EXT_FUNCT_EN adds single-cycle slt/sll decodes for aluOp=01.
module alu_ctrl_seq #(
  parameter int FUNCT_W = 4,
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       legal;
    logic       mul;
    logic       div;
  } dec_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              ov_q, ov_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;
  dec_t              dec;
  logic              funct_hi;

  // Undecoded upper funct bits must be zero for a legal R-type op.
  assign funct_hi = (bus.funct >> 4) != '0;

  always_comb begin
    dec = '{op: 4'b0000, legal: 1'b1, mul: 1'b0, div: 1'b0};
    case (bus.aluOp)
      2'b00: dec.op = 4'b0100;
      2'b11: dec.op = 4'b0111;
      2'b10: dec.op = 4'b1000;
      default: begin
        if (funct_hi) begin
          dec.legal = 1'b0;
        end else begin
          case (bus.funct[3:0])
            4'b0000: dec.op = 4'b0000;
            4'b0001: dec.op = 4'b0001;
            4'b0100: begin dec.op = 4'b0010; dec.mul = 1'b1; end
            4'b0101: begin dec.op = 4'b0011; dec.div = 1'b1; end
            4'b0111: dec.op = 4'b0100;
            4'b1000: dec.op = 4'b0101;
`ifdef ALU_CTRL_EXT_FUNCT_EN
            4'b0010: dec.op = 4'b1001;
            4'b0011: dec.op = 4'b1010;
`endif
            default: dec.legal = 1'b0;
          endcase
        end
      end
    endcase
  end

  // Next-state and next-output logic; all outputs leave the block registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ov_d    = ov_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
      stall_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall_d = 1'b0;
          ov_d    = 1'b0;
          if (bus.valid_in) begin
            if (dec.legal) begin
              op_d = OP_W'(dec.op);
              ov_d = 1'b1;
              if (dec.mul) begin
                if (MUL_LAT > 1) begin
                  state_d = MULT;
                  cnt_d   = MUL_CNT;
                  stall_d = 1'b1;
                end else begin
                  done_d = 1'b1;
                end
              end else if (dec.div) begin
                if (DIV_LAT > 1) begin
                  state_d = DIV;
                  cnt_d   = DIV_CNT;
                  stall_d = 1'b1;
                end else begin
                  done_d = 1'b1;
                end
              end
            end else begin
              op_d  = '0;
              ill_d = 1'b1;
            end
          end
        end
        // Upstream is held by stall, so request inputs are ignored here.
        MULT, DIV: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            stall_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          ov_d    = 1'b0;
          stall_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ov_q    <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ov_q    <= ov_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.operation = op_q;
  assign bus.op_valid  = ov_q;
  assign bus.stall     = stall_q;
  assign bus.done      = done_q;
  assign bus.illegal   = ill_q;

endmodule
